// File: rtl/clyde_wtk_schedule_pkg.sv
// Shared definitions for the Clyde-128 tweakey/W addition sequencer:
// slot count, W seeds, FSM encoding and the per-slot update functions.
package clyde_wtk_schedule_pkg;

  localparam int CLYDE_NSLOT = 13;
  localparam int CLYDE_NBITS = 128;
  localparam logic [3:0] W_INIT_FWD = 4'h1;
  localparam logic [3:0] W_INIT_INV = 4'hE;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // W[i] holds c_i. Forward: (c0,c1,c2,c3) -> (c1,c2,c3,c0^c1).
  function automatic logic [3:0] w_fwd(input logic [3:0] w);
    return {w[0] ^ w[1], w[3], w[2], w[1]};
  endfunction

  // Inverse: (c0,c1,c2,c3) -> (c3^c0,c0,c1,c2).
  function automatic logic [3:0] w_inv(input logic [3:0] w);
    return {w[2], w[1], w[0], w[3] ^ w[0]};
  endfunction

  // Tweak packed as {b,a} with a in the low half. Forward: (a,b) -> (a^b,a).
  function automatic logic [CLYDE_NBITS-1:0] tk_fwd(input logic [CLYDE_NBITS-1:0] t);
    logic [CLYDE_NBITS/2-1:0] a, b;
    a = t[CLYDE_NBITS/2-1:0];
    b = t[CLYDE_NBITS-1:CLYDE_NBITS/2];
    return {a, a ^ b};
  endfunction

  // Inverse: (a,b) -> (b,a^b).
  function automatic logic [CLYDE_NBITS-1:0] tk_inv(input logic [CLYDE_NBITS-1:0] t);
    logic [CLYDE_NBITS/2-1:0] a, b;
    a = t[CLYDE_NBITS/2-1:0];
    b = t[CLYDE_NBITS-1:CLYDE_NBITS/2];
    return {a ^ b, b};
  endfunction

endpackage

// File: rtl/clyde_wtk_schedule_w_lfsr.sv
// 4-bit bidirectional LFSR producing the Clyde W round constants.
// clear has priority over load, load over step.
module clyde_w_lfsr
  import clyde_wtk_schedule_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       step,
  input  logic       dir,
  output logic [3:0] w
);

  logic [3:0] w_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q <= 4'h0;
    end else if (clear) begin
      w_q <= 4'h0;
    end else if (load) begin
      w_q <= load_val;
    end else if (step) begin
      w_q <= dir ? w_inv(w_q) : w_fwd(w_q);
    end
  end

  assign w = w_q;

endmodule

// File: rtl/clyde_wtk_schedule.sv
// Walks the 13 tweakey/W addition slots of one Clyde call and presents the
// public tweak value, W constant and addition enables for the current slot.
module clyde_wtk_schedule
  import clyde_wtk_schedule_pkg::*;
#(
  parameter int Nbits  = 128,
  parameter int NSTEPS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             inverse,
  input  logic [Nbits-1:0] tweak,
  input  logic             next,
  output logic             valid,
  output logic [3:0]       slot,
  output logic             last,
  output logic             ctrl_TK_addition,
  output logic             ctrl_W_addition,
  output logic [Nbits-1:0] delta,
  output logic [3:0]       W
);

  localparam logic [3:0] LAST_SLOT = 4'(2 * NSTEPS);

  // Handshake: while valid=1 the slot outputs are stable until the consumer
  // asserts next, which retires the slot on that clock edge. next is ignored
  // when valid=0; start is only honoured while valid=0.

  state_t           state;
  logic [3:0]       slot_q;
  logic             dir_q;
  logic [Nbits-1:0] t_q;
  logic [3:0]       w_reg;

  logic run, tk_add, w_add, advance, at_last;

  assign run     = (state == ST_RUN);
  assign at_last = (slot_q == LAST_SLOT);
  assign tk_add  = run && !slot_q[0];
  assign w_add   = run && (dir_q ? (slot_q <= LAST_SLOT - 4'd1) : (slot_q >= 4'd1));
  assign advance = run && next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      slot_q <= 4'd0;
      dir_q  <= 1'b0;
      t_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RUN;
            slot_q <= 4'd0;
            dir_q  <= inverse;
            t_q    <= tweak;
          end
        end
        ST_RUN: begin
          if (next) begin
            if (at_last) begin
              state  <= ST_IDLE;
              slot_q <= 4'd0;
              t_q    <= '0;
            end else begin
              slot_q <= slot_q + 4'd1;
              if (tk_add) t_q <= dir_q ? tk_inv(t_q) : tk_fwd(t_q);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  clyde_w_lfsr u_w_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (advance && at_last),
    .load     ((state == ST_IDLE) && start),
    .load_val (inverse ? W_INIT_INV : W_INIT_FWD),
    .step     (advance && w_add),
    .dir      (dir_q),
    .w        (w_reg)
  );

  assign valid            = run;
  assign slot             = slot_q;
  assign last             = run && at_last;
  assign ctrl_TK_addition = tk_add;
  assign ctrl_W_addition  = w_add;
  assign delta            = run ? t_q : '0;
  assign W                = w_add ? w_reg : 4'h0;

endmodule

// File: doc/clyde_wtk_schedule.md
Name: clyde_wtk_schedule

Overview:
- Sequencer for the masked Clyde-128 round controller.
- Generates the per-slot W round constant, the public tweak value delta, and the ctrl_TK_addition / ctrl_W_addition enables consumed by the masked tweakey/W addition stage.
- Walks the 13 addition slots of one Clyde call, in forward (encrypt) or inverse (decrypt) order.
- Handles public values only; key shares never enter this block.

Parameters:
- Nbits, 128, state/tweak width; must be 128, tweak halves are Nbits/2.
- NSTEPS, 6, Clyde steps; slot count is 2*NSTEPS+1 = 13.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a schedule; accepted only in IDLE
- inverse  in  1  sampled with start; 1 = decrypt order
- tweak  in  Nbits  sampled with start; t0 = tweak[63:0], t1 = tweak[127:64]
- next  in  1  current slot consumed; advance
- valid  out  1  slot outputs meaningful
- slot  out  4  current slot index, 0..12
- last  out  1  valid && slot==12
- ctrl_TK_addition  out  1  add TK this slot
- ctrl_W_addition  out  1  add W this slot
- delta  out  Nbits  tweak value T_i as {b,a}, a = low half
- W  out  4  round constant, W[i] = c_i; 4'h0 when ctrl_W_addition=0

Behaviour:
- FSM: IDLE, RUN.
- Reset (rst_n=0 at a clk edge, any state) -> IDLE. slot=0, all outputs 0, internal tweak/W registers zeroed.
- IDLE:
  - valid=0, flags=0, delta=0, W=0. next is ignored.
  - start=1 -> next cycle RUN, slot=0, dir<=inverse, T<=tweak.
  - W register <= 4'h1 if forward, 4'hE if inverse.
- RUN: outputs valid combinationally from registers; valid=1.
  - next=0: hold everything.
  - next=1 with slot<12: slot+1.
  - next=1 with slot==12: IDLE next cycle; T and W registers cleared to 0.
  - start during RUN is ignored, including the cycle of slot==12 with next=1.
- Flags:
  - ctrl_TK_addition = valid && slot even.
  - Forward: ctrl_W_addition = valid && slot>=1.
  - Inverse: ctrl_W_addition = valid && slot<=11.
- Register advance happens only on next=1 in RUN.
  - W advances when leaving a slot with ctrl_W_addition=1.
    - Forward (c0..c3) -> (c1,c2,c3,c0^c1).
    - Inverse (c0..c3) -> (c3^c0,c0,c1,c2).
  - T advances when leaving a slot with ctrl_TK_addition=1.
    - Forward (a,b) -> (a^b,a).
    - Inverse (a,b) -> (b,a^b).
- Forward W sequence, slots 1..12: 1,8,4,2,9,C,6,B,5,A,D,E.
- Inverse W sequence, slots 0..11: E,D,A,5,B,6,C,9,2,4,8,1.
- TK order:
  - Forward, slots 0,2,..12: T0,T1,T2,T0,T1,T2,T0.
  - Inverse: T0,T2,T1,T0,T2,T1,T0.
  - T0 = (t0,t1), T1 = (t0^t1,t0), T2 = (t1,t0^t1).
- Latency: start -> valid is 1 cycle. With next held high, one slot per cycle; 13 valid cycles total.
- Earliest restart: start in the first IDLE cycle after completion.

Decomposition:
- Shared clyde package holds:
  - CLYDE_NSLOT=13
  - W_INIT_FWD=4'h1, W_INIT_INV=4'hE
  - an FSM state enum
  - functions w_fwd, w_inv, tk_fwd, tk_inv
- One sub-module clyde_w_lfsr (4-bit bidirectional LFSR with load/step/dir).
- Tweak update stays inline.

Test Plan:
- Forward: start, inverse=0, t0=64'h0123456789ABCDEF, t1=64'hFEDCBA9876543210, next held 1 -> 13 valid cycles.
  - W by slot: 0,1,8,4,2,9,C,6,B,5,A,D,E.
  - delta at slot 2 = {t0, 64'hFFFFFFFFFFFFFFFF}; slot 4 = {FFFF..FF, t1}; slot 12 = {t1,t0}.
  - last only at slot 12.
- Inverse, same tweak:
  - W by slot: E,D,A,5,B,6,C,9,2,4,8,1,0.
  - delta at slot 2 = {FFFF..FF, t1}; slot 4 = {t0, FFFF..FF}.
  - ctrl_W_addition=0 only at slot 12.
- Stalls: next toggled 1,0,0,1,... -> outputs frozen while next=0; same per-slot values as the forward run; completion after 13 next pulses.
- start pulsed at slot 5 and again at slot 12 together with next -> ignored; IDLE follows; a new start one cycle later -> slot 0, W per new direction.
- rst_n=0 at slot 7, then start with inverse=1 -> valid=0 and outputs 0 the cycle after reset; fresh inverse sequence starting W=E.
- next=1 in IDLE with no start -> valid stays 0, slot stays 0.
